mailbox_doorbell_agent: RTL and testbench
=========================================

# mailbox_doorbell_agent

Fabric-side client for one side (A or B) of the two-sided 3-bit mailbox interrupt register. It drives that side's wr/rd/wdata strobes and consumes rdata/rvalid/mp_irq. It services incoming doorbells (clears own MP and emits an event) and rings the remote side (sets remote MP) on request. Every register update is a read-modify-write, because the mailbox write overwrites all three bits.

## Interface
Parameters:
- TIMEOUT, 8: max cycles in WAIT for mb_rvalid before abort; legal 1..255.
- CNT_W, 16: width of evt_count.

Ports (reset is asynchronous, active-low; one clock):
- clk  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- mp_irq  in  1  this side's mailbox interrupt (own MP & own MPIE).
- mb_rdata  in  3  mailbox read data {own MPIE, own MP, remote MP}.
- mb_rvalid  in  1  read data valid, one-cycle pulse.
- mb_wr  out  1  mailbox write strobe.
- mb_rd  out  1  mailbox read strobe.
- mb_wdata  out  3  write data {own MPIE, own MP, remote MP}.
- irq_en  in  1  desired own MPIE value.
- ring_req  in  1  level request to set remote MP.
- ring_ack  out  1  one-cycle pulse: ring written.
- msg_evt  out  1  one-cycle pulse: incoming doorbell serviced.
- busy  out  1  FSM not in IDLE.
- rd_err  out  1  one-cycle pulse: read timeout.
- evt_count  out  CNT_W  count of msg_evt pulses, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, RD, WAIT, WR.
- IDLE: a trigger is any of mp_irq, ring_req, or (irq_en != en_shadow). On a trigger, latch pend_svc=mp_irq and pend_ring=ring_req, then go to RD. Otherwise stay in IDLE.
- RD: assert mb_rd for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: on mb_rvalid, capture mb_rdata into rd_q and go to WR. Otherwise increment the counter. When the counter reaches TIMEOUT: pulse rd_err, clear pend_*, return to IDLE. A still-present trigger re-arms naturally.
- WR: assert mb_wr for one cycle with:
  - mb_wdata[2] = irq_en.
  - mb_wdata[1] = pend_svc ? 0 : rd_q[1].
  - mb_wdata[0] = pend_ring ? 1 : rd_q[0].
- WR, same cycle:
  - Set en_shadow = irq_en.
  - Pulse msg_evt iff pend_svc & rd_q[1], and increment evt_count in that case.
  - Pulse ring_ack iff pend_ring.
  - Then go to IDLE.
- Simultaneous service + ring: both are merged into one write (own MP cleared, remote MP set). msg_evt and ring_ack pulse together.
- mb_wr and mb_rd are never asserted in the same cycle.
- mb_wdata is 0 when mb_wr = 0.
- ring_req is sampled only in IDLE. The requester drops it the cycle after ring_ack. If ring_req is still high in IDLE, a second ring is issued.
- irq_en changes are sampled only in IDLE. A change made mid-transaction is applied by the WR in progress if it is stable by then. Otherwise it is picked up as a new trigger.
- Reset values: state IDLE, all outputs 0, evt_count 0, en_shadow 0, pend_* 0.
- Reset asserted mid-transaction: immediately IDLE, strobes deasserted. No partial write is ever issued.
- Known limitation: a remote write landing between this agent's RD and WR is overwritten with rd_q values. Software protocol must tolerate one lost remote-MP update window of 2 cycles.

## Timing
- Cycle 0: trigger seen in IDLE.
- Cycle 1: RD, mb_rd=1, busy=1.
- Cycle 2: WAIT; mb_rvalid arrives from the mailbox (one-cycle read latency).
- Cycle 3: WR; mb_wr=1, msg_evt/ring_ack pulse.
- Cycle 4: IDLE, busy=0. mp_irq is already low if the service cleared own MP.
- Minimum gap between transactions: 1 IDLE cycle. Throughput: one RMW per 4 cycles.
- Late mb_rvalid: WAIT extends by up to TIMEOUT cycles. rd_err pulses in the cycle the count reaches TIMEOUT, and IDLE follows on the next cycle.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.

## Test plan
- Reset, irq_en=1, no mp_irq: the en_shadow mismatch triggers one RMW. With rdata=3'b000, expect wdata=3'b100 at cycle 3; no msg_evt, no ring_ack.
- mp_irq=1, rdata=3'b110: expect mb_rd at cycle 1 and mb_wr at cycle 3 with wdata=3'b100. msg_evt=1, evt_count 0->1, busy low at cycle 4.
- ring_req=1, rdata=3'b100: expect wdata=3'b101 and a single ring_ack pulse. Dropping ring_req after the ack produces no second write.
- mp_irq and ring_req together, rdata=3'b110: expect one write with wdata=3'b101; msg_evt and ring_ack pulse in the same cycle.
- mb_rvalid withheld with TIMEOUT=8: rd_err pulses exactly 8 cycles after WAIT entry and no mb_wr is issued. With the trigger still held, a retry RD follows after one IDLE cycle.
- Assert resetn=0 during WAIT: state returns to IDLE, all outputs are 0 at once, evt_count=0, and no mb_wr occurs afterward.

Source files
------------

// File: rtl/mailbox_doorbell_agent.sv
// Fabric-side agent for one side of the 3-bit mailbox interrupt register.
// Services incoming doorbells and rings the remote side, always by read-modify-write.
module mailbox_doorbell_agent #(
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             mp_irq,
   input  logic [2:0]       mb_rdata,
   input  logic             mb_rvalid,
   output logic             mb_wr,
   output logic             mb_rd,
   output logic [2:0]       mb_wdata,
   input  logic             irq_en,
   input  logic             ring_req,
   output logic             ring_ack,
   output logic             msg_evt,
   output logic             busy,
   output logic             rd_err,
   output logic [CNT_W-1:0] evt_count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_WR   = 2'd3;
   localparam logic [7:0] TMO     = 8'(TIMEOUT);

   logic [1:0]       state;
   logic             pend_svc;
   logic             pend_ring;
   logic             en_shadow;
   logic             en_q;
   logic [1:0]       rd_q;
   logic [7:0]       tmo_cnt;
   logic [CNT_W-1:0] evt_cnt_q;
   logic             trigger;
   logic             in_wr;
   logic             timed_out;
   logic             svc_hit;

   // Own MPIE read back is never needed: the write always drives irq_en.
   logic unused_rdata_mpie;
   assign unused_rdata_mpie = mb_rdata[2];

   assign trigger   = mp_irq | ring_req | (irq_en != en_shadow);
   assign in_wr     = (state == ST_WR);
   assign timed_out = (state == ST_WAIT) && (tmo_cnt == TMO);
   assign svc_hit   = pend_svc & rd_q[1];

   // irq_en is captured together with the read data so the write value is
   // registered; a change landing later is caught by the next IDLE compare.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         pend_svc  <= 1'b0;
         pend_ring <= 1'b0;
         en_shadow <= 1'b0;
         en_q      <= 1'b0;
         rd_q      <= 2'b00;
         tmo_cnt   <= 8'd0;
         evt_cnt_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  pend_svc  <= mp_irq;
                  pend_ring <= ring_req;
                  state     <= ST_RD;
               end
            end
            ST_RD: begin
               tmo_cnt <= 8'd0;
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (timed_out) begin
                  pend_svc  <= 1'b0;
                  pend_ring <= 1'b0;
                  state     <= ST_IDLE;
               end else if (mb_rvalid) begin
                  rd_q  <= mb_rdata[1:0];
                  en_q  <= irq_en;
                  state <= ST_WR;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            ST_WR: begin
               en_shadow <= en_q;
               if (svc_hit)
                  evt_cnt_q <= evt_cnt_q + CNT_W'(1);
               pend_svc  <= 1'b0;
               pend_ring <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode state and registers only.
   assign mb_rd     = (state == ST_RD);
   assign mb_wr     = in_wr;
   assign mb_wdata  = in_wr ? {en_q, ~pend_svc & rd_q[1], pend_ring | rd_q[0]} : 3'b000;
   assign msg_evt   = in_wr & svc_hit;
   assign ring_ack  = in_wr & pend_ring;
   assign busy      = (state != ST_IDLE);
   assign rd_err    = timed_out;
   assign evt_count = evt_cnt_q;

endmodule

// File: tb/tb_mailbox_doorbell_agent.sv
// Randomized scoreboard bench for mailbox_doorbell_agent with a small mailbox
// environment and a transaction-level reference model.
module tb_mailbox_doorbell_agent;

   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             mp_irq;
   logic [2:0]       mb_rdata = 3'b000;
   logic             mb_rvalid = 1'b0;
   logic             mb_wr, mb_rd;
   logic [2:0]       mb_wdata;
   logic             irq_en = 1'b0;
   logic             ring_req = 1'b0;
   logic             ring_ack, msg_evt, busy, rd_err;
   logic [CNT_W-1:0] evt_count;

   mailbox_doorbell_agent #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .mp_irq(mp_irq), .mb_rdata(mb_rdata),
      .mb_rvalid(mb_rvalid), .mb_wr(mb_wr), .mb_rd(mb_rd), .mb_wdata(mb_wdata),
      .irq_en(irq_en), .ring_req(ring_req), .ring_ack(ring_ack),
      .msg_evt(msg_evt), .busy(busy), .rd_err(rd_err), .evt_count(evt_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Mailbox register environment: {own MPIE, own MP, remote MP}
   logic [2:0] mb_reg = 3'b000;
   logic       host_wr = 1'b0;
   logic [2:0] host_val = 3'b000;
   int         rv_delay = 0;   // 255 = never answer
   logic       rv_pend = 1'b0;
   int         rv_cnt = 0;

   assign mp_irq = host_wr ? (host_val[2] & host_val[1]) : (mb_reg[2] & mb_reg[1]);

   always @(posedge clk) begin
      mb_rvalid <= 1'b0;
      if (mb_wr) mb_reg <= mb_wdata;
      else if (host_wr) mb_reg <= host_val;
      if (mb_rd && rv_delay != 255) begin
         if (rv_delay == 0) begin
            mb_rvalid <= 1'b1;
            mb_rdata  <= mb_reg;
         end else begin
            rv_pend <= 1'b1;
            rv_cnt  <= rv_delay - 1;
         end
      end else if (rv_pend) begin
         if (rv_cnt == 0) begin
            mb_rvalid <= 1'b1;
            mb_rdata  <= mb_reg;
            rv_pend   <= 1'b0;
         end else begin
            rv_cnt <= rv_cnt - 1;
         end
      end
   end

   typedef struct {
      bit             is_err;
      logic [2:0]     wd;
      bit             evt;
      bit             ack;
      logic [CNT_W-1:0] cnt;
   } exp_t;
   exp_t q[$];

   // Reference model state
   logic [2:0] mm;
   bit         shadow = 1'b0;
   int         cnt_m = 0;

   // Monitor
   initial begin
      exp_t e;
      bit cnt_chk;
      logic [CNT_W-1:0] cnt_exp;
      cnt_chk = 1'b0;
      cnt_exp = '0;
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (cnt_chk) begin
               cnt_chk = 1'b0;
               checks++;
               if (evt_count !== cnt_exp || busy !== 1'b0) begin
                  errors++;
                  $display("FAIL post_wr: evt_count=%0d busy=%0b, required evt_count=%0d busy=0",
                           evt_count, busy, cnt_exp);
               end
            end
            if (mb_rd) begin
               checks++;
               if (mb_wr || mb_wdata != 3'b000) begin
                  errors++;
                  $display("FAIL rd_excl: mb_wr=%0b wdata=%b during mb_rd, required 0/000", mb_wr, mb_wdata);
               end
            end
            if (!mb_wr && (msg_evt || ring_ack)) begin
               checks++;
               errors++;
               $display("FAIL stray_pulse: msg_evt=%0b ring_ack=%0b without mb_wr", msg_evt, ring_ack);
            end
            if (mb_wr || rd_err) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected: mb_wr=%0b rd_err=%0b wdata=%b, no transaction expected",
                           mb_wr, rd_err, mb_wdata);
               end else begin
                  e = q.pop_front();
                  if (e.is_err) begin
                     if (!(rd_err && !mb_wr)) begin
                        errors++;
                        $display("FAIL timeout_txn: mb_wr=%0b rd_err=%0b, required rd_err=1 mb_wr=0", mb_wr, rd_err);
                     end
                  end else begin
                     if (!(mb_wr && !rd_err && mb_wdata == e.wd && msg_evt == e.evt && ring_ack == e.ack)) begin
                        errors++;
                        $display("FAIL write_txn: wr=%0b err=%0b wdata=%b evt=%0b ack=%0b, required wr=1 wdata=%b evt=%0b ack=%0b",
                                 mb_wr, rd_err, mb_wdata, msg_evt, ring_ack, e.wd, e.evt, e.ack);
                     end
                     cnt_chk = 1'b1;
                     cnt_exp = e.cnt;
                  end
               end
            end
         end
      end
   end

   task automatic wait_done(output bit ok, output int rdc, output int donec);
      ok = 1'b0;
      rdc = -100;
      donec = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         host_wr = 1'b0;
         if (mb_rd) rdc = cyc;
         if (mb_wr || rd_err) begin
            ok = 1'b1;
            donec = cyc;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL txn_wait: no mb_wr/rd_err within 40 cycles, required one");
      end
   endtask

   task automatic do_step(input logic [2:0] m, input bit e, input bit r, input int d);
      bit rr, trig, svc, ok, after_err, saw_rd;
      int dd, rdc, dc, err_c, ntx;
      logic [2:0] wd;
      exp_t x;
      host_val = m;
      host_wr  = 1'b1;
      irq_en   = e;
      ring_req = r;
      rv_delay = d;
      mm = m; rr = r; dd = d; after_err = 1'b0; err_c = 0; ntx = 0;
      for (int k = 0; k < 4; k++) begin
         trig = (mm[2] & mm[1]) | rr | (e != shadow);
         if (!trig) break;
         ntx++;
         svc = mm[2] & mm[1];
         if (dd >= TIMEOUT) begin
            x.is_err = 1'b1; x.wd = 3'b000; x.evt = 1'b0; x.ack = 1'b0; x.cnt = '0;
            q.push_back(x);
            wait_done(ok, rdc, dc);
            if (ok) begin
               checks++;
               if (dc != rdc + 1 + TIMEOUT) begin
                  errors++;
                  $display("FAIL timeout_lat: rd_err %0d cycles after mb_rd, required %0d", dc - rdc, 1 + TIMEOUT);
               end
            end
            dd = 0; rv_delay = 0; after_err = 1'b1; err_c = dc;
         end else begin
            wd = {e, svc ? 1'b0 : mm[1], rr ? 1'b1 : mm[0]};
            if (svc) cnt_m = (cnt_m + 1) % (1 << CNT_W);
            x.is_err = 1'b0; x.wd = wd; x.evt = svc; x.ack = rr; x.cnt = CNT_W'(cnt_m);
            q.push_back(x);
            wait_done(ok, rdc, dc);
            if (ok) begin
               checks++;
               if (dc != rdc + 2 + dd || (after_err && rdc != err_c + 2)) begin
                  errors++;
                  $display("FAIL latency: rd@%0d wr@%0d (last err@%0d), required wr=rd+%0d%s",
                           rdc, dc, err_c, 2 + dd, after_err ? " and rd=err+2" : "");
               end
            end
            if (rr) ring_req = 1'b0;
            rr = 1'b0; mm = wd; shadow = e; after_err = 1'b0;
         end
      end
      if (ntx == 0) begin
         saw_rd = 1'b0;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host_wr = 1'b0;
            if (mb_rd) saw_rd = 1'b1;
         end
         checks++;
         if (saw_rd || busy) begin
            errors++;
            $display("FAIL idle_quiet: saw_rd=%0b busy=%0b with no trigger, required 0/0", saw_rd, busy);
         end
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic rand_steps(input int n);
      int r8, d;
      for (int i = 0; i < n; i++) begin
         r8 = $urandom_range(0, 7);
         d = (r8 == 0) ? 255 : ((r8 < 4) ? 0 : $urandom_range(1, TIMEOUT - 1));
         do_step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0, d);
      end
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      checks++;
      if ({mb_wr, mb_rd, mb_wdata, ring_ack, msg_evt, busy, rd_err} != 9'd0 || evt_count != '0) begin
         errors++;
         $display("FAIL reset_state: outputs=%b evt_count=%0d, required all 0", 
                  {mb_wr, mb_rd, mb_wdata, ring_ack, msg_evt, busy, rd_err}, evt_count);
      end
      resetn = 1'b1;
      @(negedge clk);

      do_step(3'b000, 1'b1, 1'b0, 0);           // en_shadow mismatch -> 100
      do_step(3'b110, 1'b1, 1'b0, 0);           // service -> 100, msg_evt
      do_step(3'b100, 1'b1, 1'b1, 0);           // ring -> 101
      do_step(3'b110, 1'b1, 1'b1, 0);           // merged service + ring
      do_step(3'b000, 1'b1, 1'b1, 255);         // timeout, then retry
      do_step(3'b100, 1'b1, 1'b1, TIMEOUT - 1); // latest accepted rvalid
      do_step(3'b010, 1'b0, 1'b0, 0);           // disable MPIE, MP stays
      do_step(3'b010, 1'b1, 1'b0, 0);           // enable exposes MP -> chained service
      do_step(3'b011, 1'b1, 1'b0, 0);           // nothing to do

      rand_steps(150);

      // Reset in WAIT
      host_val = 3'b000; host_wr = 1'b1; ring_req = 1'b1; rv_delay = 255;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         host_wr = 1'b0;
         if (mb_rd) break;
      end
      @(negedge clk);
      resetn = 1'b0;
      #1;
      checks++;
      if ({mb_wr, mb_rd, mb_wdata, ring_ack, msg_evt, busy, rd_err} != 9'd0 || evt_count != '0) begin
         errors++;
         $display("FAIL reset_mid: outputs=%b evt_count=%0d, required all 0",
                  {mb_wr, mb_rd, mb_wdata, ring_ack, msg_evt, busy, rd_err}, evt_count);
      end
      ring_req = 1'b0; irq_en = 1'b0; rv_delay = 0;
      q.delete();
      shadow = 1'b0; cnt_m = 0; mm = 3'b000;
      @(negedge clk);
      resetn = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (mb_wr || mb_rd) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL post_reset_quiet: %0d strobe cycles after reset, required 0", n);
      end

      rand_steps(40);

      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected transactions unseen, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
